// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and flush control for the 5-stage pipeline.
// Tracks EX/MEM/WB occupancy, stalls the front end on load-use and flushes on MEM redirects.
//
//   state | meaning
//   RUN   | normal flow; a load-use hazard stalls for one cycle here
//   HOLD  | extra load-use bubbles; cnt_q counts the stall cycles still to go
module pipe_hazard_unit #(
    parameter int ADDR_W     = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [ADDR_W-1:0] id_rs_i,
    input  logic [ADDR_W-1:0] id_rt_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic [ADDR_W-1:0] id_dst_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              mem_redirect_i,
    output logic              pc_en_o,
    output logic              if_id_en_o,
    output logic              id_ex_en_o,
    output logic              bubble_o,
    output logic [2:0]        flush_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  stall_cycles_o
);

    typedef enum logic {ST_RUN, ST_HOLD} state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic [ADDR_W-1:0] dst;
        logic              reg_write;
        logic              mem_read;
    } ex_entry_t;

    // Beyond EX only the write-back identity matters for forwarding.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dst;
        logic              reg_write;
    } wr_entry_t;

    localparam logic [3:0] HOLD_INIT = 4'(LOAD_STALL - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    ex_entry_t        ex_q, ex_d;
    wr_entry_t        mem_q, mem_d;
    wr_entry_t        wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic hazard;
    logic redirect;
    logic stall;

    function automatic logic [1:0] fwd_sel(input wr_entry_t mem_e, input wr_entry_t wb_e,
                                           input logic [ADDR_W-1:0] src);
        if (mem_e.valid && mem_e.reg_write && (mem_e.dst != '0) && (mem_e.dst == src))
            return 2'b10;
        else if (wb_e.valid && wb_e.reg_write && (wb_e.dst != '0) && (wb_e.dst == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.dst != '0) &&
                    ((id_uses_rs_i && (id_rs_i == ex_q.dst)) ||
                     (id_uses_rt_i && (id_rt_i == ex_q.dst)));
    assign redirect = enable_i && mem_redirect_i;
    assign stall    = enable_i && !mem_redirect_i && ((state_q == ST_HOLD) || hazard);

    assign pc_en_o        = enable_i && !stall;
    assign if_id_en_o     = enable_i && !stall;
    assign id_ex_en_o     = enable_i;
    assign bubble_o       = stall || redirect;
    assign flush_o        = {3{redirect}};
    assign fwd_a_o        = fwd_sel(mem_q, wb_q, ex_q.rs);
    assign fwd_b_o        = fwd_sel(mem_q, wb_q, ex_q.rt);
    assign stall_cycles_o = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;

        if (redirect) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else if (enable_i) begin
            case (state_q)
                ST_RUN: begin
                    if (hazard && (LOAD_STALL > 1)) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_INIT;
                    end
                end
                ST_HOLD: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1)
                        state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end

        if (enable_i) begin
            wb_d            = mem_q;
            mem_d.valid     = ex_q.valid && !redirect;
            mem_d.dst       = ex_q.dst;
            mem_d.reg_write = ex_q.reg_write;
            ex_d.valid      = !(stall || redirect);
            ex_d.rs         = id_rs_i;
            ex_d.rt         = id_rt_i;
            ex_d.dst        = id_dst_i;
            ex_d.reg_write  = id_reg_write_i;
            ex_d.mem_read   = id_mem_read_i;
        end

        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: LOAD_STALL=1/CNT_W=16 and LOAD_STALL=3/CNT_W=4 instances share stimulus.
// Directed scenarios use fixed expectations; the random run compares against an instruction-level model.
module tb_pipe_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, redir;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       id_uses_rs, id_uses_rt, id_rw, id_mr;

    logic        pc_en [2];
    logic        if_id_en [2];
    logic        id_ex_en [2];
    logic        bubble [2];
    logic [2:0]  flush [2];
    logic [1:0]  fwd_a [2];
    logic [1:0]  fwd_b [2];
    logic [15:0] sc1;
    logic [3:0]  sc3;
    int          sc [2];

    always_comb begin
        sc[0] = int'(sc1);
        sc[1] = int'(sc3);
    end

    int errors = 0;
    int checks = 0;

    pipe_hazard_unit #(.ADDR_W(5), .LOAD_STALL(1), .CNT_W(16)) u_ls1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt),
        .id_dst_i(id_dst), .id_reg_write_i(id_rw), .id_mem_read_i(id_mr),
        .mem_redirect_i(redir),
        .pc_en_o(pc_en[0]), .if_id_en_o(if_id_en[0]), .id_ex_en_o(id_ex_en[0]),
        .bubble_o(bubble[0]), .flush_o(flush[0]), .fwd_a_o(fwd_a[0]), .fwd_b_o(fwd_b[0]),
        .stall_cycles_o(sc1)
    );

    pipe_hazard_unit #(.ADDR_W(5), .LOAD_STALL(3), .CNT_W(4)) u_ls3 (
        .clk_i(clk), .rst_i(rst), .enable_i(en),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt),
        .id_dst_i(id_dst), .id_reg_write_i(id_rw), .id_mem_read_i(id_mr),
        .mem_redirect_i(redir),
        .pc_en_o(pc_en[1]), .if_id_en_o(if_id_en[1]), .id_ex_en_o(id_ex_en[1]),
        .bubble_o(bubble[1]), .flush_o(flush[1]), .fwd_a_o(fwd_a[1]), .fwd_b_o(fwd_b[1]),
        .stall_cycles_o(sc3)
    );

    // Reference model: instructions occupying EX/MEM/WB plus remaining hold cycles.
    typedef struct {
        bit v;
        int rs, rt, dst;
        bit rw, mr;
    } ins_t;

    ins_t m_ex [2];
    ins_t m_mem [2];
    ins_t m_wb [2];
    int   m_rem [2];
    int   m_cnt [2];

    function automatic int ls_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int cmax_of(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    function automatic bit m_hazard(input int k);
        return m_ex[k].v && m_ex[k].mr && (m_ex[k].dst != 0) &&
               ((id_uses_rs && (int'(id_rs) == m_ex[k].dst)) ||
                (id_uses_rt && (int'(id_rt) == m_ex[k].dst)));
    endfunction

    function automatic bit m_stall(input int k);
        return en && !redir && ((m_rem[k] > 0) || m_hazard(k));
    endfunction

    function automatic logic [1:0] m_fwd(input int k, input int src);
        if (m_mem[k].v && m_mem[k].rw && (m_mem[k].dst != 0) && (m_mem[k].dst == src)) return 2'b10;
        if (m_wb[k].v && m_wb[k].rw && (m_wb[k].dst != 0) && (m_wb[k].dst == src)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_ex[k]  = '{0, 0, 0, 0, 0, 0};
                m_mem[k] = '{0, 0, 0, 0, 0, 0};
                m_wb[k]  = '{0, 0, 0, 0, 0, 0};
                m_rem[k] = 0;
                m_cnt[k] = 0;
            end else if (en) begin
                bit st, hz;
                st = m_stall(k);
                hz = m_hazard(k);
                m_wb[k]  = m_mem[k];
                m_mem[k] = m_ex[k];
                if (redir) m_mem[k].v = 0;
                m_ex[k] = '{!(st || redir), int'(id_rs), int'(id_rt), int'(id_dst), id_rw, id_mr};
                if (redir)              m_rem[k] = 0;
                else if (m_rem[k] > 0)  m_rem[k] = m_rem[k] - 1;
                else if (hz)            m_rem[k] = ls_of(k) - 1;
                if (st && (m_cnt[k] < cmax_of(k))) m_cnt[k] = m_cnt[k] + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input int rs, input int rt, input bit urs, input bit urt,
                          input int dst, input bit rw, input bit mr);
        id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
        id_dst = 5'(dst); id_rw = rw; id_mr = mr;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; redir = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({pc_en[k], if_id_en[k], id_ex_en[k], bubble[k]} !== 4'b1110) begin
                errors++; $display("FAIL reset_ctrl[%0d] got=%b exp=1110", k,
                                   {pc_en[k], if_id_en[k], id_ex_en[k], bubble[k]});
            end
            checks++;
            if ({flush[k], fwd_a[k], fwd_b[k]} !== 7'b0 || sc[k] != 0) begin
                errors++; $display("FAIL reset_out[%0d] flush=%b fwd_a=%b fwd_b=%b sc=%0d exp all 0",
                                   k, flush[k], fwd_a[k], fwd_b[k], sc[k]);
            end
        end
        step();
    endtask

    task automatic test_forward();
        do_reset();
        set_id(1, 2, 1, 1, 3, 1, 0); step();
        set_id(3, 4, 1, 1, 6, 1, 0); step();
        set_id(7, 3, 1, 1, 8, 1, 0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (fwd_a[k] !== 2'b10 || fwd_b[k] !== 2'b00) begin
                errors++; $display("FAIL fwd_mem[%0d] a=%b b=%b exp a=10 b=00", k, fwd_a[k], fwd_b[k]);
            end
        end
        step();
        set_id(1, 1, 1, 1, 9, 1, 0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (fwd_a[k] !== 2'b00 || fwd_b[k] !== 2'b01) begin
                errors++; $display("FAIL fwd_wb[%0d] a=%b b=%b exp a=00 b=01", k, fwd_a[k], fwd_b[k]);
            end
        end
        step();
        set_id(2, 2, 1, 1, 9, 1, 0); step();
        set_id(9, 9, 1, 1, 10, 1, 0); step();
        set_id(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (fwd_a[k] !== 2'b10 || fwd_b[k] !== 2'b10) begin
                errors++; $display("FAIL fwd_prio[%0d] a=%b b=%b exp a=10 b=10", k, fwd_a[k], fwd_b[k]);
            end
        end
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 0, 1, 0, 5, 1, 1); step();
        set_id(2, 5, 1, 1, 7, 1, 0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({pc_en[k], if_id_en[k], id_ex_en[k], bubble[k], flush[k]} !== 7'b0011000) begin
                errors++; $display("FAIL lu_stall[%0d] got=%b exp=0011000", k,
                                   {pc_en[k], if_id_en[k], id_ex_en[k], bubble[k], flush[k]});
            end
        end
        step();
        @(negedge clk);
        checks++;
        if (pc_en[0] !== 1'b1 || sc[0] != 1) begin
            errors++; $display("FAIL lu1_release pc_en=%b sc=%0d exp pc_en=1 sc=1", pc_en[0], sc[0]);
        end
        checks++;
        if (pc_en[1] !== 1'b0 || sc[1] != 1) begin
            errors++; $display("FAIL lu3_hold1 pc_en=%b sc=%0d exp pc_en=0 sc=1", pc_en[1], sc[1]);
        end
        step();
        @(negedge clk);
        checks++;
        if (fwd_a[0] !== 2'b00 || fwd_b[0] !== 2'b01) begin
            errors++; $display("FAIL lu1_fwd a=%b b=%b exp a=00 b=01", fwd_a[0], fwd_b[0]);
        end
        checks++;
        if (pc_en[1] !== 1'b0 || sc[1] != 2) begin
            errors++; $display("FAIL lu3_hold2 pc_en=%b sc=%0d exp pc_en=0 sc=2", pc_en[1], sc[1]);
        end
        step();
        @(negedge clk);
        checks++;
        if (pc_en[1] !== 1'b1 || bubble[1] !== 1'b0 || sc[1] != 3) begin
            errors++; $display("FAIL lu3_release pc_en=%b bubble=%b sc=%0d exp 1 0 3",
                               pc_en[1], bubble[1], sc[1]);
        end
        step();
        @(negedge clk);
        checks++;
        if (fwd_b[1] !== 2'b00 || sc[0] != 1) begin
            errors++; $display("FAIL lu3_fwd b=%b sc1=%0d exp b=00 sc1=1", fwd_b[1], sc[0]);
        end
        step();
    endtask

    task automatic test_redirect();
        do_reset();
        set_id(1, 0, 1, 0, 5, 1, 1); step();
        set_id(2, 5, 1, 1, 7, 1, 0); step();
        set_id(0, 0, 0, 0, 0, 0, 0);
        redir = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (flush[k] !== 3'b111 || pc_en[k] !== 1'b1 || if_id_en[k] !== 1'b1 || bubble[k] !== 1'b1) begin
                errors++; $display("FAIL redir_out[%0d] flush=%b pc_en=%b if_id=%b bubble=%b exp 111 1 1 1",
                                   k, flush[k], pc_en[k], if_id_en[k], bubble[k]);
            end
        end
        checks++;
        if (sc[1] != 1) begin
            errors++; $display("FAIL redir_sc got=%0d exp=1", sc[1]);
        end
        step();
        redir = 1'b0;
        @(negedge clk);
        checks++;
        if (pc_en[1] !== 1'b1 || bubble[1] !== 1'b0 || fwd_a[1] !== 2'b00 || fwd_b[1] !== 2'b00 || sc[1] != 1) begin
            errors++; $display("FAIL redir_after pc_en=%b bubble=%b a=%b b=%b sc=%0d exp 1 0 00 00 1",
                               pc_en[1], bubble[1], fwd_a[1], fwd_b[1], sc[1]);
        end
        step();
        // Hazard and redirect together: the redirect must swallow the stall entirely.
        do_reset();
        set_id(1, 0, 1, 0, 5, 1, 1); step();
        set_id(2, 5, 1, 1, 7, 1, 0);
        redir = 1'b1;
        @(negedge clk);
        checks++;
        if (pc_en[1] !== 1'b1 || flush[1] !== 3'b111) begin
            errors++; $display("FAIL both_out pc_en=%b flush=%b exp 1 111", pc_en[1], flush[1]);
        end
        step();
        redir = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (sc[0] != 0 || sc[1] != 0 || pc_en[1] !== 1'b1) begin
            errors++; $display("FAIL both_after sc1=%0d sc3=%0d pc_en=%b exp 0 0 1", sc[0], sc[1], pc_en[1]);
        end
        step();
    endtask

    task automatic test_r0();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_id($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                   0, 1'($urandom), 1'($urandom));
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (pc_en[k] !== 1'b1 || fwd_a[k] !== 2'b00 || fwd_b[k] !== 2'b00) begin
                    errors++; $display("FAIL r0[%0d] cyc=%0d pc_en=%b a=%b b=%b exp 1 00 00",
                                       k, i, pc_en[k], fwd_a[k], fwd_b[k]);
                end
            end
            step();
        end
    endtask

    task automatic test_enable_freeze();
        do_reset();
        set_id(1, 0, 1, 0, 5, 1, 1); step();
        set_id(2, 5, 1, 1, 7, 1, 0); step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (pc_en[1] !== 1'b0 || id_ex_en[1] !== 1'b0 || sc[1] != 1) begin
                errors++; $display("FAIL freeze cyc=%0d pc_en=%b id_ex=%b sc=%0d exp 0 0 1",
                                   i, pc_en[1], id_ex_en[1], sc[1]);
            end
            step();
        end
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (pc_en[1] !== 1'b0 || bubble[1] !== 1'b1) begin
                errors++; $display("FAIL resume cyc=%0d pc_en=%b bubble=%b exp 0 1", i, pc_en[1], bubble[1]);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (pc_en[1] !== 1'b1 || sc[1] != 3) begin
            errors++; $display("FAIL resume_end pc_en=%b sc=%0d exp 1 3", pc_en[1], sc[1]);
        end
        step();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int n = 1; n <= 6; n++) begin
            set_id(1, 0, 1, 0, 5, 1, 1); step();
            set_id(2, 5, 1, 1, 7, 1, 0);
            repeat (3) step();
            if (n >= 5) begin
                @(negedge clk);
                checks++;
                if (sc[1] != 15) begin
                    errors++; $display("FAIL sat loop=%0d sc=%0d exp=15", n, sc[1]);
                end
            end
        end
        checks++;
        if (sc[0] != 6) begin
            errors++; $display("FAIL sat_wide sc=%0d exp=6", sc[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            en    = ($urandom_range(0, 9) != 0);
            redir = ($urandom_range(0, 9) == 0);
            set_id($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 2) == 0));
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                bit st;
                logic [12:0] got, exp;
                st  = m_stall(k);
                got = {pc_en[k], if_id_en[k], id_ex_en[k], bubble[k], flush[k], fwd_a[k], fwd_b[k], 2'b00};
                exp = {en && !st, en && !st, en, en && (st || redir), (en && redir) ? 3'b111 : 3'b000,
                       m_fwd(k, m_ex[k].rs), m_fwd(k, m_ex[k].rt), 2'b00};
                checks++;
                if (got !== exp) begin
                    errors++; $display("FAIL rand_out[%0d] cyc=%0d got=%b exp=%b", k, i, got, exp);
                end
                checks++;
                if (sc[k] != m_cnt[k]) begin
                    errors++; $display("FAIL rand_sc[%0d] cyc=%0d got=%0d exp=%0d", k, i, sc[k], m_cnt[k]);
                end
            end
            step();
        end
        rst = 1'b0; en = 1'b1; redir = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; redir = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_forward();
        test_load_use();
        test_redirect();
        test_r0();
        test_enable_freeze();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
